// File: rtl/ysyx_25040105_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC and FSM encodings.
package ysyx_25040105_ifu_pkg;

  localparam int          IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // Two-bit fetch FSM encoding
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25040105_reg.sv
// Generic register with write enable and a parameterised synchronous reset value.
module ysyx_25040105_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Load d when enabled; reset wins over write
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else if (we) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: one instruction in flight, registered handshakes toward imem and decode.
module ysyx_25040105_ifu
  import ysyx_25040105_ifu_pkg::*;
#(
  parameter int               XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic [31:0]     fetch_cnt
);

  ifu_state_e      state_q, state_d;
  logic            req_valid_q, req_valid_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_we;
  logic            cnt_we;
  logic [31:0]     cnt_q;

  // PC register: reloaded only when commit hands over the next PC
  ysyx_25040105_reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .we  (pc_we),
    .d   (npc),
    .q   (pc_q)
  );

  // Delivered-instruction counter, wraps naturally at 2^32
  ysyx_25040105_reg #(
    .WIDTH     (32),
    .RESET_VAL (32'd0)
  ) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .we  (cnt_we),
    .d   (cnt_q + 32'd1),
    .q   (cnt_q)
  );

  // Next-state and next-output computation; valids are derived from the next state
  // so the handshake outputs come straight from flops
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    pc_we   = 1'b0;
    cnt_we  = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (pc_q[1:0] != 2'b00) begin
          // Misaligned PC never reaches the bus; report it as a fetch fault
          inst_d  = 32'd0;
          fault_d = 1'b1;
          state_d = S_OUT;
        end else if (req_valid_q && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_err ? 32'd0 : imem_rsp_data[31:0];
          fault_d = imem_rsp_err;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          cnt_we  = 1'b1;
          state_d = S_NPC;
        end
      end
      S_NPC: begin
        if (npc_valid) begin
          pc_we   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    pc_d        = pc_we ? npc : pc_q;
    req_valid_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
    out_valid_d = (state_d == S_OUT);
  end

  // FSM state and registered outputs; reset drops any in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      inst_q      <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_fault      = fault_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Directed self-checking bench for the instruction fetch unit.
module tb_ysyx_25040105_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int acc_base;

  ysyx_25040105_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted imem requests
  always @(posedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0;
    imem_rsp_err = 1'b0;
    out_ready = 1'b0;
    npc_valid = 1'b0;
    npc = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_fault", out_fault, 0);
    check("rst_addr", imem_req_addr, 32'h8000_0000);

    // Basic fetch
    rst = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    check("t1_req_valid", imem_req_valid, 1);
    check("t1_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    check("t1_req_dropped", imem_req_valid, 0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_out_pc", out_pc, 32'h8000_0000);
    check("t1_out_inst", out_inst, 32'h0010_0093);
    check("t1_out_fault", out_fault, 0);
    check("t1_cnt_before", fetch_cnt, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_out_valid_low", out_valid, 0);
    check("t1_cnt_after", fetch_cnt, 1);
    npc_valid = 1'b1;
    npc = 32'h8000_0004;
    tick();
    npc_valid = 1'b0;
    check("t1_next_req_valid", imem_req_valid, 1);
    check("t1_next_req_addr", imem_req_addr, 32'h8000_0004);

    // Backpressure on request channel
    acc_base = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_valid", imem_req_valid, 1);
      check("t2_hold_addr", imem_req_addr, 32'h8000_0004);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("t2_req_dropped", imem_req_valid, 0);
    check("t2_one_accept", acc_cnt - acc_base, 1);

    // Bus error response
    imem_rsp_valid = 1'b1;
    imem_rsp_err = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    check("t3_out_valid", out_valid, 1);
    check("t3_fault", out_fault, 1);
    check("t3_inst_zero", out_inst, 0);
    check("t3_out_pc", out_pc, 32'h8000_0004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_cnt", fetch_cnt, 2);

    // Misaligned next PC: fault without a bus request
    acc_base = acc_cnt;
    imem_req_ready = 1'b1;
    npc_valid = 1'b1;
    npc = 32'h8000_0006;
    tick();
    npc_valid = 1'b0;
    check("t4_no_req_a", imem_req_valid, 0);
    tick();
    check("t4_no_req_b", imem_req_valid, 0);
    check("t4_out_valid", out_valid, 1);
    check("t4_fault", out_fault, 1);
    check("t4_inst_zero", out_inst, 0);
    check("t4_out_pc", out_pc, 32'h8000_0006);
    check("t4_no_accept", acc_cnt - acc_base, 0);
    imem_req_ready = 1'b0;

    // Decode stalls; spurious response and npc pulses must be ignored
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = (i == 1);
      imem_rsp_data = 32'h1234_5678;
      npc_valid = (i == 2);
      npc = 32'h0000_1234;
      tick();
      check("t5_valid_stable", out_valid, 1);
      check("t5_inst_stable", out_inst, 0);
      check("t5_fault_stable", out_fault, 1);
      check("t5_pc_stable", out_pc, 32'h8000_0006);
    end
    imem_rsp_valid = 1'b0;
    npc_valid = 1'b0;
    check("t5_cnt_hold", fetch_cnt, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_cnt", fetch_cnt, 3);

    // Reset while waiting for a response
    npc_valid = 1'b1;
    npc = 32'h8000_0008;
    tick();
    npc_valid = 1'b0;
    check("t6_req_addr", imem_req_addr, 32'h8000_0008);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("t6_in_wait", imem_req_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_addr", imem_req_addr, 32'h8000_0000);
    check("t6_rst_cnt", fetch_cnt, 0);
    check("t6_rst_out_valid", out_valid, 0);
    tick();
    check("t6_req_valid", imem_req_valid, 1);
    check("t6_req_addr2", imem_req_addr, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
